// File: rtl/accum_pkg.sv
// Shared types and constants for the running-sum accumulator.
package accum_pkg;

   localparam int ACCUM_DATA_W = 32;

   typedef logic [ACCUM_DATA_W-1:0] accum_word_t;

   localparam accum_word_t ACCUM_ZERO = '0;
   localparam accum_word_t ACCUM_MAX  = '1;

endpackage : accum_pkg

// File: rtl/accum_adder.sv
// Unsigned DATA_W-bit adder that reports its carry-out separately from the sum.
module accum_adder
   import accum_pkg::*;
#(
   parameter int DATA_W = ACCUM_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum,
   output logic              carry_out
);

   // Widen by one bit so the carry falls out of the top of the result.
   always_comb begin
      {carry_out, sum} = {1'b0, a} + {1'b0, b};
   end

endmodule : accum_adder

// File: rtl/modport_accumulator.sv
// Running-sum accumulator: accum <= accum + data on enabled cycles.
// Priority at each rising edge: reset_n (active-high) > clear > enable > hold.
// Optional macro ACCUM_SATURATE_EN: additions clamp at all-ones and a sticky
// ovf output reports the first saturating add; without it the sum wraps.
module modport_accumulator
   import accum_pkg::*;
#(
   parameter int DATA_W = ACCUM_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data,
   input  logic              enable,
   input  logic              clear,
   output logic [DATA_W-1:0] accum
`ifdef ACCUM_SATURATE_EN
   ,
   output logic              ovf
`endif
);

   logic [DATA_W-1:0] accum_p0;
   logic [DATA_W-1:0] sum;
   logic              carry;
   logic [DATA_W-1:0] next_sum;

   accum_adder #(
      .DATA_W (DATA_W)
   ) u_adder (
      .a         (accum_p0),
      .b         (data),
      .sum       (sum),
      .carry_out (carry)
   );

`ifdef ACCUM_SATURATE_EN
   logic ovf_p0;

   // Clamp to all-ones when the add carries out of DATA_W bits.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] s,
                                                input logic              c);
      return c ? {DATA_W{1'b1}} : s;
   endfunction

   // Select the clamped sum for the register input.
   always_comb begin
      next_sum = sat_add(sum, carry);
   end

   // Sticky overflow flag, cleared only by reset or clear.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         ovf_p0 <= 1'b0;
      end else if (clear) begin
         ovf_p0 <= 1'b0;
      end else if (enable && carry) begin
         ovf_p0 <= 1'b1;
      end
   end

   assign ovf = ovf_p0;
`else
   logic unused_carry;

   assign unused_carry = carry;

   // Plain modulo-2^DATA_W wrap; the carry is discarded.
   always_comb begin
      next_sum = sum;
   end
`endif

   // ---- stage p0: running-sum register with reset > clear > enable > hold
   always_ff @(posedge clk) begin
      if (reset_n) begin
         accum_p0 <= '0;
      end else if (clear) begin
         accum_p0 <= '0;
      end else if (enable) begin
         accum_p0 <= next_sum;
      end
   end

   assign accum = accum_p0;

endmodule : modport_accumulator

// File: tb/tb_modport_accumulator.sv
// Self-checking bench for modport_accumulator: directed cases from the
// behavioural description followed by randomized traffic against a model.
// Honours ACCUM_SATURATE_EN to match the build of the design.
module tb_modport_accumulator;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [W-1:0] data = '0;
   logic         enable = 1'b0;
   logic         clear = 1'b0;
   logic [W-1:0] accum;
`ifdef ACCUM_SATURATE_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   // Reference state: the mathematical running sum under the chosen rule.
   longint unsigned model_sum = 0;
   bit              model_ovf = 1'b0;

   always #5 clk = ~clk;

   modport_accumulator #(.DATA_W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .enable  (enable),
      .clear   (clear),
      .accum   (accum)
`ifdef ACCUM_SATURATE_EN
      ,
      .ovf     (ovf)
`endif
   );

   task automatic check(input string tag, input longint unsigned got,
                        input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance the reference by one rising edge.
   task automatic model_edge(input bit r, input bit c, input bit e,
                             input longint unsigned d);
      longint unsigned total;
      if (r || c) begin
         model_sum = 0;
         model_ovf = 1'b0;
      end else if (e) begin
         total = model_sum + d;
`ifdef ACCUM_SATURATE_EN
         if (total > 64'hFFFF_FFFF) begin
            model_sum = 64'hFFFF_FFFF;
            model_ovf = 1'b1;
         end else begin
            model_sum = total;
         end
`else
         model_sum = total % 64'h1_0000_0000;
`endif
      end
   endtask

   // Drive one cycle of inputs, let one rising edge happen, check at the falling edge.
   task automatic step(input string tag, input bit r, input bit c, input bit e,
                       input logic [W-1:0] d);
      reset_n = r;
      clear   = c;
      enable  = e;
      data    = d;
      @(posedge clk);
      model_edge(r, c, e, longint'(d));
      @(negedge clk);
      check(tag, longint'(accum), model_sum);
`ifdef ACCUM_SATURATE_EN
      check({tag, "_ovf"}, longint'(ovf), longint'(model_ovf));
`endif
   endtask

   initial begin
      @(negedge clk);

      // Reset held with enable asserted, then released with enable low.
      step("rst0", 1, 0, 1, 32'h5);
      step("rst1", 1, 0, 1, 32'h5);
      check("rst_zero", longint'(accum), 0);
      step("idle0", 0, 0, 0, 32'h5);
      step("idle1", 0, 0, 0, 32'h5);

      // Accumulate 1,2,3,4 then hold.
      step("acc1", 0, 0, 1, 32'd1);
      check("acc1_abs", longint'(accum), 1);
      step("acc2", 0, 0, 1, 32'd2);
      step("acc3", 0, 0, 1, 32'd3);
      step("acc4", 0, 0, 1, 32'd4);
      check("acc4_abs", longint'(accum), 10);
      for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 32'hDEAD_BEEF);
      check("hold_abs", longint'(accum), 10);

      // Unknown data while disabled must not disturb the sum.
      step("xdata", 0, 0, 0, 'x);

      // Clear beats enable; next enabled cycle starts from zero.
      step("clr", 0, 1, 1, 32'h7);
      check("clr_abs", longint'(accum), 0);
      step("clr_next", 0, 0, 1, 32'h7);
      check("clr_next_abs", longint'(accum), 7);

      // Carry-out boundary.
      step("pre_clr", 0, 1, 0, 32'h0);
      step("load", 0, 0, 1, 32'hFFFF_FFF0);
      step("boundary", 0, 0, 1, 32'h20);
`ifdef ACCUM_SATURATE_EN
      check("sat_abs", longint'(accum), 64'hFFFF_FFFF);
      check("sat_ovf_abs", longint'(ovf), 1);
      step("sat_add0", 0, 0, 1, 32'h0);
      step("sat_more", 0, 0, 1, 32'h1);
      step("sat_clr", 0, 1, 0, 32'h0);
      check("sat_clr_ovf_abs", longint'(ovf), 0);
`else
      check("wrap_abs", longint'(accum), 64'h10);
      step("wrap_edge_clr", 0, 1, 0, 32'h0);
      step("wrap_edge_ld", 0, 0, 1, 32'hFFFF_FFFF);
      step("wrap_edge", 0, 0, 1, 32'h1);
      check("wrap_edge_abs", longint'(accum), 0);
`endif

      // Reset in the middle of a run.
      step("mid_clr", 0, 1, 0, 32'h0);
      step("mid_load", 0, 0, 1, 32'h100);
      step("mid_rst", 1, 0, 1, 32'h9);
      check("mid_rst_abs", longint'(accum), 0);
      step("mid_after", 0, 0, 1, 32'h9);
      check("mid_after_abs", longint'(accum), 9);

      // Randomized traffic; large addends make both wrap and saturation common.
      for (int i = 0; i < 400; i++) begin
         bit r, c, e;
         logic [W-1:0] d;
         r = ($urandom_range(0, 39) == 0);
         c = ($urandom_range(0, 19) == 0);
         e = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       d = W'($urandom_range(0, 15));
            1:       d = 32'hFFFF_FFFF - W'($urandom_range(0, 15));
            default: d = $urandom;
         endcase
         step("rand", r, c, e, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_modport_accumulator

// File: doc/modport_accumulator.md
Name: modport_accumulator

Overview:
- Single-clock 32-bit running-sum accumulator.
- Adds `data` into an internal register on every enabled cycle.
- Supports a synchronous `clear` and exposes the registered sum on `accum`.
- Leaf datapath block, driven on the rising clock edge; downstream logic samples `accum` at the following falling edge.

Parameters:
- DATA_W, 32, width of `data` and `accum` in bits (legal range 8–64).

Ports:
- clk      input   1        sole clock; all state updates on rising edge
- reset_n  input   1        synchronous, active-high reset. The port name follows codebase convention; a logic 1 resets the block.
- data     input   DATA_W   addend, sampled at rising edge when enable=1
- enable   input   1        1 = accumulate `data` this cycle
- clear    input   1        1 = zero the accumulator this cycle
- accum    output  DATA_W   registered running sum
- ovf      output  1        present only with ACCUM_SATURATE_EN (see Optional Feature)

Behaviour:
- Reset: at a rising edge with reset_n=1, accum <= 0 and ovf <= 0. Reset overrides clear and enable.
- Priority at each rising edge: reset_n > clear > enable > hold.
- clear=1 (reset_n=0): accum <= 0, regardless of enable or data; the data on that cycle is discarded. ovf <= 0.
- enable=1, clear=0: accum <= accum + data. Both operands are unsigned DATA_W bits. By default the result wraps modulo 2^DATA_W and the carry is discarded.
- enable=0, clear=0: accum holds its value.
- Latency: one cycle. The effect of inputs sampled at rising edge N is visible on accum after edge N, stable by the following falling edge.
- accum is driven directly from a flop; there is no combinational path from inputs to accum.
- X on data while enable=0 must not affect accum.
- Reset asserted mid-accumulation: the sum is lost, and accumulation resumes from 0 on the first enabled cycle after reset_n returns to 0.
- Wrap boundary (default build): 0xFFFF_FFFF + 0x0000_0001 -> 0x0000_0000; no flag is raised.

Optional Feature:
- Macro: ACCUM_SATURATE_EN
- Defined:
  - Addition saturates: if accum + data carries out, accum <= all-ones (0xFFFF_FFFF) and stays there on further adds.
  - Output port ovf is added: a sticky flag set on the first saturating add, cleared only by reset_n or clear.
  - When already saturated, adding 0 keeps accum at all-ones and keeps ovf=1.
- Undefined:
  - Modulo-2^DATA_W wrap as above.
  - ovf port and its logic are absent.

Decomposition:
- Package accum_pkg holds:
  - localparam ACCUM_DATA_W = 32 (default for DATA_W)
  - typedef logic [ACCUM_DATA_W-1:0] accum_word_t
  - constants ACCUM_ZERO and ACCUM_MAX (all-ones).
- One natural sub-module: accum_adder.
  - Combinational: inputs a, b; outputs sum and carry_out.
  - Top-level holds the register, the priority mux, and the optional saturation/ovf logic.

Test Plan:
- Reset: hold reset_n=1 for 2 cycles with enable=1, data=0x5 -> accum=0 throughout; after release with enable=0, accum stays 0.
- Accumulate: enable=1 with data 1, 2, 3, 4 on consecutive cycles -> accum reads 1, 3, 6, 10 at successive falling edges. Then enable=0 for 3 cycles -> holds at 10.
- Clear priority: accum=10, then clear=1 with enable=1, data=0x7 -> accum=0. Next cycle clear=0, enable=1, data=0x7 -> accum=7.
- Wrap (default): accum=0xFFFF_FFF0, add 0x20 -> accum=0x0000_0010.
- Saturate (ACCUM_SATURATE_EN): accum=0xFFFF_FFF0, add 0x20 -> accum=0xFFFF_FFFF, ovf=1. Add 0 -> unchanged. clear -> accum=0, ovf=0.
- Mid-run reset: accum=0x100, pulse reset_n=1 for one cycle while enable=1, data=0x9 -> accum=0. Next enabled cycle with data=0x9 -> accum=9.
